wb_arbiter: RTL

Writeback stage directly upstream of reg_file. It merges two writeback sources onto the register file's single write port (w_en/wa3/wd3):
- the in-order pipeline result, which has fixed priority;
- the long-latency aux result (mul/div/load), which uses a valid/ready handshake and a small FIFO.
It exports a pending-destination mask so decode can stall RAW/WAW hazards on queued aux results.

---
 rtl/wb_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges the pipeline result (fixed priority) and the aux result
// (valid/ready + FIFO) onto the single reg_file write port.
// Ports:
//   clk, rst           - clock, async active-high reset
//   pipe_wen/rd/wd     - in-order pipeline writeback
//   aux_valid/ready    - aux handshake
//   aux_rd/wd          - aux destination and data
//   w_en/wa3/wd3       - registered reg_file write port
//   pending_mask       - destinations held in the FIFO
//   fifo_full/count    - FIFO occupancy for decode stalls
module wb_arbiter #(
  parameter int word_width = 32,
  parameter int addr_width = 5,
  parameter int depth      = 4,
  localparam int nregs     = 1 << addr_width,
  localparam int cw        = $clog2(depth + 1),
  localparam int pw        = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_wen,
  input  logic [addr_width-1:0] pipe_rd,
  input  logic [word_width-1:0] pipe_wd,
  input  logic                  aux_valid,
  output logic                  aux_ready,
  input  logic [addr_width-1:0] aux_rd,
  input  logic [word_width-1:0] aux_wd,
  output logic                  w_en,
  output logic [addr_width-1:0] wa3,
  output logic [word_width-1:0] wd3,
  output logic [nregs-1:0]      pending_mask,
  output logic                  fifo_full,
  output logic [cw-1:0]         fifo_count
);

  logic [addr_width-1:0] rd_mem [depth];
  logic [word_width-1:0] wd_mem [depth];
  logic [depth-1:0]      vld;
  logic [pw-1:0]         wr_ptr;
  logic [pw-1:0]         rd_ptr;
  logic [cw-1:0]         count;

  logic pipe_use;
  logic acc_nz;
  logic empty;
  logic pop;
  logic bypass;
  logic push;

  assign fifo_count = count;
  assign fifo_full  = (count == cw'(depth));
  assign empty      = (count == '0);
  // Held low during reset so no aux result is lost to a clearing FIFO.
  assign aux_ready  = !rst && !fifo_full;

  assign pipe_use = pipe_wen && (pipe_rd != '0);
  assign acc_nz   = aux_valid && aux_ready && (aux_rd != '0);
  assign pop      = !pipe_use && !empty;
  assign bypass   = !pipe_use && empty && acc_nz;
  assign push     = acc_nz && !bypass;

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < depth; i++) begin
      if (vld[i]) pending_mask[rd_mem[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
      for (int i = 0; i < depth; i++) begin
        rd_mem[i] <= '0;
        wd_mem[i] <= '0;
      end
    end else begin
      count <= count + cw'(push) - cw'(pop);
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + pw'(1);
      end
      // A same-cycle pop never hits the tail slot unless empty, and empty
      // excludes pop, so the push write always wins cleanly.
      if (push) begin
        vld[wr_ptr]    <= 1'b1;
        rd_mem[wr_ptr] <= aux_rd;
        wd_mem[wr_ptr] <= aux_wd;
        wr_ptr         <= wr_ptr + pw'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en <= 1'b0;
      wa3  <= '0;
      wd3  <= '0;
    end else begin
      w_en <= pipe_use || pop || bypass;
      if (pipe_use) begin
        wa3 <= pipe_rd;
        wd3 <= pipe_wd;
      end else if (pop) begin
        wa3 <= rd_mem[rd_ptr];
        wd3 <= wd_mem[rd_ptr];
      end else if (bypass) begin
        wa3 <= aux_rd;
        wd3 <= aux_wd;
      end
    end
  end

endmodule
